cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter and driver for the common data bus (CDB) of the `risc_v_superscalar` out-of-order core. Each cycle it picks at most one of `N_REQ` functional-unit result ports (ALU, MUL, DIV, LSU in the default build). It grants the winner in the same cycle and broadcasts the winner's tag and data on a registered CDB one cycle later. Reservation stations, the register status table and the ROB consume the CDB.

## Interface
- `N_REQ`, default 4: number of requesting functional units; must be ≥2. Index 0=ALU, 1=MUL, 2=DIV, 3=LSU.
- `TAG_W`, default 6: width of the result tag (ROB/RS index).
- `DATA_W`, default 32: width of the result data.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-low (asserted when 0, sampled on rising `clk`).
- `req_valid`  in  N_REQ: bit i high means unit i holds a completed result.
- `req_tag`  in  N_REQ*TAG_W: packed tags; unit i occupies bits [i*TAG_W +: TAG_W].
- `req_data`  in  N_REQ*DATA_W: packed results; unit i occupies bits [i*DATA_W +: DATA_W].
- `flush`  in  1: branch mispredict squash; suppresses arbitration this cycle.
- `req_grant`  out  N_REQ: one-hot or zero combinational grant for the current cycle.
- `cdb_valid`  out  1: registered broadcast valid.
- `cdb_tag`  out  TAG_W: registered broadcast tag.
- `cdb_data`  out  DATA_W: registered broadcast data.
- `cdb_src`  out  $clog2(N_REQ): index of the unit whose result is on the CDB.

## Operation
- State:
  - `rr_ptr` ($clog2(N_REQ) bits): highest-priority index for the next arbitration.
  - The four CDB output registers.
- Arbitration is combinational:
  - Scan indices `rr_ptr`, `rr_ptr+1`, … modulo N_REQ.
  - The first i with `req_valid[i]`=1 wins, and `req_grant[i]`=1.
  - All other grant bits are 0.
- `req_grant` is forced to all zeros while `rst`=0 or `flush`=1.
- On a grant to unit i at a rising edge:
  - `cdb_valid` <= 1, `cdb_tag` <= tag i, `cdb_data` <= data i, `cdb_src` <= i.
  - `rr_ptr` <= (i+1) mod N_REQ.
- No grant (no requests, or flush): `cdb_valid` <= 0. `cdb_tag`, `cdb_data` and `cdb_src` hold. `rr_ptr` holds.
- Requester contract:
  - A unit holds `req_valid`, `req_tag` and `req_data` stable until it samples its grant.
  - The unit deasserts or presents a new result in the cycle after the grant.
  - The arbiter does not latch ungranted requests.
- Fairness: a continuously requesting unit is granted within N_REQ cycles. No starvation is possible.
- Flush:
  - No grant is issued in the flush cycle.
  - The CDB shows `cdb_valid`=0 in the following cycle.
  - A broadcast already registered before the flush still completes in the flush cycle. The ROB discards it by tag.
  - Units are responsible for dropping squashed requests.
- Reset (`rst`=0 at a rising edge, including mid-operation):
  - `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0, `cdb_src`=0, `rr_ptr`=0.
  - An in-flight broadcast is lost.

## Timing
- Grant latency: 0 cycles. `req_grant` is valid in the same cycle `req_valid` rises.
- Broadcast latency: 1 cycle. A result granted in cycle t appears on the CDB during cycle t+1 only.
- Throughput: one broadcast per cycle. Back-to-back grants to different units, or to the same unit, are allowed.
- `cdb_valid` is a single-cycle pulse per grant. Consecutive grants produce a continuously high `cdb_valid`, with new tag and data each cycle.
- Simultaneous `flush` and `rst`=0: reset dominates, and all outputs and `rr_ptr` are cleared.
- Wrap-around: a grant to index N_REQ-1 sets `rr_ptr` to 0.
- No combinational path exists from `req_*` to any `cdb_*` output.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with all `req_valid`=4'b1111, then release.
  - `req_grant`=0 and `cdb_valid`=0 throughout reset.
  - The first grant after release is 4'b0001, with `cdb_src`=0 one cycle later.
- Round-robin: hold `req_valid`=4'b1111 for 8 cycles, each unit presenting tag = 10+i.
  - Grant sequence is 0,1,2,3,0,1,2,3.
  - CDB tags are 10,11,12,13,… each one cycle behind the grants.
  - `cdb_valid` stays high continuously.
- Pointer skip/wrap: after a grant to unit 2, request only 4'b0011.
  - Unit 0 is granted, then unit 1.
  - `rr_ptr` wraps through 3 to 0 correctly.
- Single unit: DIV alone requests with tag 6'h2A, data 32'hDEADBEEF for 1 cycle.
  - `req_grant`=4'b0100.
  - Next cycle: `cdb_valid`=1, tag 2A, data DEADBEEF, `cdb_src`=2.
  - The cycle after: `cdb_valid`=0 with tag and data held.
- Flush: assert `flush` for 1 cycle while 4'b1010 is requesting.
  - `req_grant`=0 in that cycle.
  - `cdb_valid`=0 in the next cycle.
  - `rr_ptr` is unchanged, so the following grant goes to the same unit that would have won.
- Reset mid-broadcast: assert `rst`=0 in the cycle after a grant.
  - `cdb_valid`, `cdb_tag`, `cdb_data` and `cdb_src` are all 0 at the following edge.
  - After release, arbitration restarts at unit 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Purpose: round-robin arbiter that picks one functional-unit result per cycle and drives the registered CDB.
// Latency: grant is combinational (0 cycles); the broadcast appears on cdb_* one cycle after the grant.
// Backpressure: none on the CDB; ungranted units keep req_valid/tag/data stable until they see req_grant.
//
// Ports:
//   clk, rst         clock and synchronous active-low reset
//   req_valid        per-unit "result ready" bits
//   req_tag/data     packed per-unit tag/data, unit i at [i*W +: W]
//   flush            squash: no grant this cycle, pointer holds
//   req_grant        one-hot (or zero) combinational grant
//   cdb_valid/tag/data/src  registered broadcast of last cycle's winner
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int PW     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    flush,
  output logic [N_REQ-1:0]        req_grant,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [PW-1:0]           cdb_src
);

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win_idx;
  logic              win_found;
  logic              grant_any;
  logic [TAG_W-1:0]  tag_arr  [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];
  int                idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign tag_arr[g]  = req_tag[g*TAG_W +: TAG_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Scan from rr_ptr upward with wrap; the first requester found wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // Reset and flush both mask the grant; the registers below key off grant_any only.
  assign grant_any = win_found && rst && !flush;

  always_comb begin
    req_grant = '0;
    if (grant_any) req_grant[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (grant_any) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= tag_arr[win_idx];
      cdb_data  <= data_arr[win_idx];
      cdb_src   <= win_idx;
      rr_ptr    <= (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + PW'(1);
    end else begin
      // Payload and pointer hold; only the valid pulse ends.
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int N = 4;
  localparam int TW = 6;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic            flush;
  logic [N-1:0]    req_grant;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;

  logic [TW-1:0] tags  [N];
  logic [DW-1:0] datas [N];

  always_comb begin
    req_tag  = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = tags[i];
      req_data[i*DW +: DW] = datas[i];
    end
  end

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .flush     (flush),
    .req_grant (req_grant),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  g;
    logic          cv;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Monitor: outputs are sampled mid-cycle, one expectation per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("req_grant", 32'(req_grant), 32'(e.g));
      check("cdb_valid", 32'(cdb_valid), 32'(e.cv));
      check("cdb_tag",   32'(cdb_tag),   32'(e.tag));
      check("cdb_data",  cdb_data,       e.data);
      check("cdb_src",   32'(cdb_src),   32'(e.src));
    end
  end

  // One cycle: drive inputs just after the edge and queue what the monitor should see.
  // Expected cdb_* is the result of the previous cycle's grant; grant is from this cycle's inputs.
  task automatic cyc(input logic r, input logic f, input logic [N-1:0] v,
                     input logic [N-1:0] eg, input logic ecv, input int etag,
                     input logic [DW-1:0] edata, input int esrc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    flush = f;
    req_valid = v;
    e.g = eg; e.cv = ecv; e.tag = TW'(etag); e.data = edata; e.src = 2'(esrc);
    exp_q.push_back(e);
  endtask

  task automatic default_payload();
    for (int i = 0; i < N; i++) begin
      tags[i]  = TW'(10 + i);
      datas[i] = 32'h1000_0000 + 32'(i);
    end
  endtask

  localparam logic [DW-1:0] D0 = 32'h1000_0000;
  localparam logic [DW-1:0] D1 = 32'h1000_0001;
  localparam logic [DW-1:0] D2 = 32'h1000_0002;
  localparam logic [DW-1:0] D3 = 32'h1000_0003;

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    req_valid = 4'b1111;
    default_payload();

    // Reset held 3 cycles with everyone requesting.
    cyc(0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    cyc(0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    cyc(0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    // Round robin over 8 cycles, CDB one cycle behind.
    cyc(1, 0, 4'b1111, 4'b0001, 0, 0,  0,  0);
    cyc(1, 0, 4'b1111, 4'b0010, 1, 10, D0, 0);
    cyc(1, 0, 4'b1111, 4'b0100, 1, 11, D1, 1);
    cyc(1, 0, 4'b1111, 4'b1000, 1, 12, D2, 2);
    cyc(1, 0, 4'b1111, 4'b0001, 1, 13, D3, 3);
    cyc(1, 0, 4'b1111, 4'b0010, 1, 10, D0, 0);
    cyc(1, 0, 4'b1111, 4'b0100, 1, 11, D1, 1);
    cyc(1, 0, 4'b1111, 4'b1000, 1, 12, D2, 2);
    // Grant unit 2 (ptr->3), then only 0011: wrap to 0, then 1.
    cyc(1, 0, 4'b0100, 4'b0100, 1, 13, D3, 3);
    cyc(1, 0, 4'b0011, 4'b0001, 1, 12, D2, 2);
    cyc(1, 0, 4'b0011, 4'b0010, 1, 10, D0, 0);
    cyc(1, 0, 4'b0000, 4'b0000, 1, 11, D1, 1);
    // DIV alone with a distinctive payload.
    tags[2]  = 6'h2A;
    datas[2] = 32'hDEAD_BEEF;
    cyc(1, 0, 4'b0100, 4'b0100, 0, 11,    D1,           1);
    cyc(1, 0, 4'b0000, 4'b0000, 1, 'h2A,  32'hDEADBEEF, 2);
    cyc(1, 0, 4'b0000, 4'b0000, 0, 'h2A,  32'hDEADBEEF, 2);
    default_payload();
    // Flush with 1010 requesting; ptr=3 so unit 3 wins once flush drops.
    cyc(1, 1, 4'b1010, 4'b0000, 0, 'h2A,  32'hDEADBEEF, 2);
    cyc(1, 0, 4'b1010, 4'b1000, 0, 'h2A,  32'hDEADBEEF, 2);
    cyc(1, 0, 4'b0000, 4'b0000, 1, 13,    D3,           3);
    // Reset in the cycle after a grant to unit 1 (ptr->2 before reset).
    cyc(1, 0, 4'b0010, 4'b0010, 0, 13, D3, 3);
    cyc(0, 0, 4'b0010, 4'b0000, 1, 11, D1, 1);
    cyc(1, 0, 4'b1111, 4'b0001, 0, 0,  0,  0);
    cyc(1, 0, 4'b0000, 4'b0000, 1, 10, D0, 0);
    // Reset together with flush: reset wins and clears everything.
    cyc(0, 1, 4'b1111, 4'b0000, 0, 10, D0, 0);
    cyc(1, 0, 4'b0100, 4'b0100, 0, 0,  0,  0);
    cyc(1, 0, 4'b0000, 4'b0000, 1, 12, D2, 2);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
